stage4_mem: RTL and testbench

//   Memory-access stage of the 5-stage in-order pipeline; sits between stage3_EX and stage5_WB.

---
 rtl/stage4_mem_if.sv | 40 ++++
 rtl/stage4_mem.sv | 111 +++++++++++
 tb/tb_stage4_mem.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stage4_mem_if.sv
// Pipeline-side bus bundle of the memory-access stage: EX->MEM input, MEM->WB output,
// MEM->ID forwarding and the synchronous data SRAM read data.
interface stage4_mem_if #(
    parameter int unsigned ES_BUS_W = 76,
    parameter int unsigned MS_BUS_W = 70,
    parameter int unsigned FWD_W    = 39
);
    logic                ws_allow_in;
    logic                ms_allow_in;
    logic                es_to_ms_valid;
    logic                ms_to_ws_valid;
    logic [ES_BUS_W-1:0] es_to_ms_bus;
    logic [MS_BUS_W-1:0] ms_to_ws_bus;
    logic [FWD_W-1:0]    ms_to_ds_bus;
    logic [31:0]         data_sram_rdata;

    // Environment side (EX, WB, ID, SRAM).
    modport master (
        output ws_allow_in,
        input  ms_allow_in,
        output es_to_ms_valid,
        input  ms_to_ws_valid,
        output es_to_ms_bus,
        input  ms_to_ws_bus,
        input  ms_to_ds_bus,
        output data_sram_rdata
    );

    // The MEM stage itself.
    modport slave (
        input  ws_allow_in,
        output ms_allow_in,
        input  es_to_ms_valid,
        output ms_to_ws_valid,
        input  es_to_ms_bus,
        output ms_to_ws_bus,
        output ms_to_ds_bus,
        input  data_sram_rdata
    );
endinterface

// File: rtl/stage4_mem.sv
// Memory-access stage: captures the EX->MEM bus, extends SRAM load data, and buffers the
// one-cycle-valid SRAM read data while WB back-pressures.
module stage4_mem #(
    parameter int unsigned ES_BUS_W = 76,
    parameter int unsigned MS_BUS_W = 70,
    parameter int unsigned FWD_W    = 39
) (
    input  logic        clk,
    input  logic        reset,
    stage4_mem_if.slave pipe
);

    logic                ms_valid;
    logic                ms_ready_go;
    logic [ES_BUS_W-1:0] bus_reg;
    logic [31:0]         rdata_buf;
    logic                buf_vld;
    logic                first;

    logic [4:0]  ld_op;
    logic [31:0] alu_result;
    logic [4:0]  dest;
    logic        res_from_mem;
    logic        gr_we;
    logic [31:0] pc;

    logic [31:0] raw;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] final_result;

    assign ms_ready_go = 1'b1;

    assign ld_op        = bus_reg[75:71];
    assign alu_result   = bus_reg[70:39];
    assign dest         = bus_reg[38:34];
    assign res_from_mem = bus_reg[33];
    assign gr_we        = bus_reg[32];
    assign pc           = bus_reg[31:0];

    // Handshake towards EX and WB; WB readiness never feeds ms_to_ws_valid.
    always_comb begin
        pipe.ms_allow_in    = !ms_valid | (ms_ready_go & pipe.ws_allow_in);
        pipe.ms_to_ws_valid = ms_valid & ms_ready_go;
    end

    // Stage valid bit, captured bus and first-cycle marker.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid <= 1'b0;
            bus_reg  <= '0;
            first    <= 1'b0;
        end else begin
            if (pipe.ms_allow_in) begin
                ms_valid <= pipe.es_to_ms_valid;
            end
            if (pipe.es_to_ms_valid & pipe.ms_allow_in) begin
                bus_reg <= pipe.es_to_ms_bus;
            end
            // SRAM data belongs to this load only in the cycle right after it entered.
            first <= pipe.es_to_ms_valid & pipe.ms_allow_in;
        end
    end

    // Hold SRAM read data while WB stalls; leaving MEM clears the hold before a new entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_buf <= '0;
            buf_vld   <= 1'b0;
        end else if (ms_valid & ms_ready_go & pipe.ws_allow_in) begin
            buf_vld <= 1'b0;
        end else if (ms_valid & first & res_from_mem & !pipe.ws_allow_in) begin
            rdata_buf <= pipe.data_sram_rdata;
            buf_vld   <= 1'b1;
        end
    end

    // Byte/half extraction and sign/zero extension of the load data.
    always_comb begin
        raw = buf_vld ? rdata_buf : pipe.data_sram_rdata;
        byte_sel = raw[7:0];
        unique case (alu_result[1:0])
            2'd0: byte_sel = raw[7:0];
            2'd1: byte_sel = raw[15:8];
            2'd2: byte_sel = raw[23:16];
            2'd3: byte_sel = raw[31:24];
            default: byte_sel = raw[7:0];
        endcase
        half_sel = alu_result[1] ? raw[31:16] : raw[15:0];

        load_data = raw;
        if (ld_op[1]) begin
            load_data = {{24{byte_sel[7]}}, byte_sel};
        end else if (ld_op[2]) begin
            load_data = {24'd0, byte_sel};
        end else if (ld_op[3]) begin
            load_data = {{16{half_sel[15]}}, half_sel};
        end else if (ld_op[4]) begin
            load_data = {16'd0, half_sel};
        end
        final_result = res_from_mem ? load_data : alu_result;
    end

    // Write-back bus and forwarding bus; an empty slot never advertises a register write.
    always_comb begin
        pipe.ms_to_ws_bus = {final_result, dest, gr_we, pc};
        pipe.ms_to_ds_bus = {gr_we & ms_valid, dest, res_from_mem & ms_valid, final_result};
    end

endmodule

// File: tb/tb_stage4_mem.sv
// Directed bench for the memory-access stage: load extension, WB stall buffering,
// back-to-back flow, bubbles and mid-operation reset.
module tb_stage4_mem;

    localparam logic [4:0] LD_W  = 5'b00001;
    localparam logic [4:0] LD_B  = 5'b00010;
    localparam logic [4:0] LD_BU = 5'b00100;
    localparam logic [4:0] LD_H  = 5'b01000;
    localparam logic [4:0] LD_HU = 5'b10000;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    stage4_mem_if pipe_if ();

    stage4_mem dut (
        .clk   (clk),
        .reset (reset),
        .pipe  (pipe_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [75:0] mk_es(input logic [4:0] op, input logic [31:0] alu,
                                          input logic [4:0] dst, input logic rfm,
                                          input logic we, input logic [31:0] pc);
        return {op, alu, dst, rfm, we, pc};
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pipe_if.ws_allow_in     = 1'b0;
        pipe_if.es_to_ms_valid  = 1'b0;
        pipe_if.es_to_ms_bus    = '0;
        pipe_if.data_sram_rdata = '0;
        #3;
        n_total++;
        if (pipe_if.ms_allow_in !== 1'b1)
            $display("FAIL reset_allow_in got %b want 1", pipe_if.ms_allow_in);
        else n_pass++;
        n_total++;
        if (pipe_if.ms_to_ws_valid !== 1'b0)
            $display("FAIL reset_ws_valid got %b want 0", pipe_if.ms_to_ws_valid);
        else n_pass++;
        n_total++;
        if (pipe_if.ms_to_ws_bus !== 70'd0 || pipe_if.ms_to_ds_bus !== 39'd0)
            $display("FAIL reset_buses got %h/%h want 0/0", pipe_if.ms_to_ws_bus,
                     pipe_if.ms_to_ds_bus);
        else n_pass++;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_ld_b();
        pipe_if.ws_allow_in    = 1'b1;
        pipe_if.es_to_ms_valid = 1'b1;
        pipe_if.es_to_ms_bus   = mk_es(LD_B, 32'h1003, 5'd3, 1'b1, 1'b1, 32'h100);
        tick();
        pipe_if.es_to_ms_valid  = 1'b0;
        pipe_if.data_sram_rdata = 32'h80FF_0102;
        #1;
        n_total++;
        if (pipe_if.ms_to_ws_valid !== 1'b1)
            $display("FAIL ldb_valid got %b want 1", pipe_if.ms_to_ws_valid);
        else n_pass++;
        n_total++;
        if (pipe_if.ms_to_ws_bus !== {32'hFFFF_FF80, 5'd3, 1'b1, 32'h100})
            $display("FAIL ldb_ws_bus got %h want %h", pipe_if.ms_to_ws_bus,
                     {32'hFFFF_FF80, 5'd3, 1'b1, 32'h100});
        else n_pass++;
        n_total++;
        if (pipe_if.ms_to_ds_bus !== {1'b1, 5'd3, 1'b1, 32'hFFFF_FF80})
            $display("FAIL ldb_ds_bus got %h want %h", pipe_if.ms_to_ds_bus,
                     {1'b1, 5'd3, 1'b1, 32'hFFFF_FF80});
        else n_pass++;
        tick();
        n_total++;
        if (pipe_if.ms_to_ws_valid !== 1'b0)
            $display("FAIL ldb_drain got %b want 0", pipe_if.ms_to_ws_valid);
        else n_pass++;
    endtask

    // One load with no stall; checks the final_result field.
    task automatic run_load(input string name, input logic [4:0] op, input logic [31:0] addr,
                            input logic rfm, input logic [31:0] rdata,
                            input logic [31:0] expected);
        pipe_if.ws_allow_in    = 1'b1;
        pipe_if.es_to_ms_valid = 1'b1;
        pipe_if.es_to_ms_bus   = mk_es(op, addr, 5'd7, rfm, 1'b1, 32'h200);
        tick();
        pipe_if.es_to_ms_valid  = 1'b0;
        pipe_if.data_sram_rdata = rdata;
        #1;
        n_total++;
        if (pipe_if.ms_to_ws_valid !== 1'b1 || pipe_if.ms_to_ws_bus[69:38] !== expected)
            $display("FAIL %s got v=%b %h want v=1 %h", name, pipe_if.ms_to_ws_valid,
                     pipe_if.ms_to_ws_bus[69:38], expected);
        else n_pass++;
        tick();
    endtask

    task automatic test_ld_half();
        run_load("ldhu", LD_HU, 32'h2002, 1'b1, 32'hBEEF_1234, 32'h0000_BEEF);
        run_load("ldh", LD_H, 32'h2002, 1'b1, 32'hBEEF_1234, 32'hFFFF_BEEF);
        run_load("ldh_a0_ignored", LD_H, 32'h2003, 1'b1, 32'hBEEF_1234, 32'hFFFF_BEEF);
        run_load("ldh_low", LD_H, 32'h2000, 1'b1, 32'hBEEF_1234, 32'h0000_1234);
        run_load("ldb_pos", LD_B, 32'h2002, 1'b1, 32'h0071_0000, 32'h0000_0071);
        run_load("ldw_misalign", LD_W, 32'h2001, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D);
        run_load("ldop0_raw", 5'b00000, 32'h2002, 1'b1, 32'h1357_9BDF, 32'h1357_9BDF);
        run_load("alu_pass", LD_B, 32'h0000_0abc, 1'b0, 32'hFFFF_FFFF, 32'h0000_0ABC);
    endtask

    task automatic test_stall_ld_w();
        pipe_if.ws_allow_in    = 1'b1;
        pipe_if.es_to_ms_valid = 1'b1;
        pipe_if.es_to_ms_bus   = mk_es(LD_W, 32'h3000, 5'd9, 1'b1, 1'b1, 32'h300);
        tick();
        pipe_if.es_to_ms_valid  = 1'b0;
        pipe_if.ws_allow_in     = 1'b0;
        pipe_if.data_sram_rdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_total++;
            if (pipe_if.ms_to_ws_valid !== 1'b1 || pipe_if.ms_allow_in !== 1'b0 ||
                pipe_if.ms_to_ws_bus[69:38] !== 32'hDEAD_BEEF)
                $display("FAIL stall_cycle%0d got v=%b allow=%b %h want v=1 allow=0 deadbeef",
                         c, pipe_if.ms_to_ws_valid, pipe_if.ms_allow_in,
                         pipe_if.ms_to_ws_bus[69:38]);
            else n_pass++;
            tick();
            pipe_if.data_sram_rdata = 32'h0;
        end
        pipe_if.ws_allow_in = 1'b1;
        #1;
        n_total++;
        if (pipe_if.ms_to_ws_valid !== 1'b1 || pipe_if.ms_allow_in !== 1'b1 ||
            pipe_if.ms_to_ws_bus[69:38] !== 32'hDEAD_BEEF)
            $display("FAIL stall_release got v=%b allow=%b %h want v=1 allow=1 deadbeef",
                     pipe_if.ms_to_ws_valid, pipe_if.ms_allow_in, pipe_if.ms_to_ws_bus[69:38]);
        else n_pass++;
        tick();
        n_total++;
        if (pipe_if.ms_to_ws_valid !== 1'b0)
            $display("FAIL stall_once got %b want 0", pipe_if.ms_to_ws_valid);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        pipe_if.ws_allow_in    = 1'b1;
        pipe_if.es_to_ms_valid = 1'b1;
        pipe_if.es_to_ms_bus   = mk_es(5'b0, 32'h5, 5'd4, 1'b0, 1'b1, 32'h400);
        tick();
        pipe_if.es_to_ms_bus   = mk_es(LD_BU, 32'h1, 5'd5, 1'b1, 1'b1, 32'h404);
        #1;
        n_total++;
        if (pipe_if.ms_to_ws_valid !== 1'b1 || pipe_if.ms_allow_in !== 1'b1 ||
            pipe_if.ms_to_ws_bus !== {32'h5, 5'd4, 1'b1, 32'h400})
            $display("FAIL b2b_add got v=%b allow=%b %h want v=1 allow=1 %h",
                     pipe_if.ms_to_ws_valid, pipe_if.ms_allow_in, pipe_if.ms_to_ws_bus,
                     {32'h5, 5'd4, 1'b1, 32'h400});
        else n_pass++;
        tick();
        pipe_if.es_to_ms_valid  = 1'b0;
        pipe_if.data_sram_rdata = 32'h0000_AB00;
        #1;
        n_total++;
        if (pipe_if.ms_to_ws_valid !== 1'b1 || pipe_if.ms_allow_in !== 1'b1 ||
            pipe_if.ms_to_ws_bus !== {32'hAB, 5'd5, 1'b1, 32'h404})
            $display("FAIL b2b_ldbu got v=%b allow=%b %h want v=1 allow=1 %h",
                     pipe_if.ms_to_ws_valid, pipe_if.ms_allow_in, pipe_if.ms_to_ws_bus,
                     {32'hAB, 5'd5, 1'b1, 32'h404});
        else n_pass++;
        tick();
    endtask

    task automatic test_bubble();
        pipe_if.ws_allow_in    = 1'b1;
        pipe_if.es_to_ms_valid = 1'b0;
        pipe_if.es_to_ms_bus   = mk_es(5'b0, 32'h77, 5'd6, 1'b0, 1'b1, 32'h500);
        tick();
        n_total++;
        if (pipe_if.ms_to_ds_bus[38] !== 1'b0 || pipe_if.ms_to_ds_bus[32] !== 1'b0 ||
            pipe_if.ms_to_ws_valid !== 1'b0)
            $display("FAIL bubble got we=%b rfm=%b v=%b want 0 0 0", pipe_if.ms_to_ds_bus[38],
                     pipe_if.ms_to_ds_bus[32], pipe_if.ms_to_ws_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        pipe_if.ws_allow_in    = 1'b1;
        pipe_if.es_to_ms_valid = 1'b1;
        pipe_if.es_to_ms_bus   = mk_es(LD_W, 32'h6000, 5'd8, 1'b1, 1'b1, 32'h600);
        tick();
        pipe_if.es_to_ms_valid  = 1'b0;
        pipe_if.ws_allow_in     = 1'b0;
        pipe_if.data_sram_rdata = 32'h1122_3344;
        tick();
        reset = 1'b1;
        #1;
        n_total++;
        if (pipe_if.ms_to_ws_valid !== 1'b0 || pipe_if.ms_allow_in !== 1'b1 ||
            pipe_if.ms_to_ds_bus !== 39'd0)
            $display("FAIL midreset got v=%b allow=%b ds=%h want v=0 allow=1 ds=0",
                     pipe_if.ms_to_ws_valid, pipe_if.ms_allow_in, pipe_if.ms_to_ds_bus);
        else n_pass++;
        tick();
        reset = 1'b0;
        #1;
        n_total++;
        if (pipe_if.ms_allow_in !== 1'b1 || pipe_if.ms_to_ws_valid !== 1'b0)
            $display("FAIL postreset got allow=%b v=%b want allow=1 v=0",
                     pipe_if.ms_allow_in, pipe_if.ms_to_ws_valid);
        else n_pass++;
        // A stale read buffer would surface 0x11223344 here.
        run_load("postreset_load", LD_W, 32'h7000, 1'b1, 32'h5566_7788, 32'h5566_7788);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_ld_b();
        test_ld_half();
        test_stall_ld_w();
        test_back_to_back();
        test_bubble();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
